// File: rtl/mips_register_file.sv
// Architectural register file for the single-cycle MIPS datapath: 32 x DATA_W registers,
// two combinational read ports (ALU operands A/B) and one clocked write port.
module mips_register_file #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_3FFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int SP_IDX   = 29;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Writes to $zero are dropped here; the read path forces it to zero as well.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != '0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Flat 32:1 mux per port; the index-0 force is the only extra logic on this path.
    assign read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
    assign read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];

endmodule

// File: doc/mips_register_file.md
# mips_register_file

Architectural register file for the single-cycle MIPS datapath: 32 general-purpose registers of 32 bits, two combinational read ports and one clocked write port. Sits directly upstream of the ALU. The two read ports drive the ALU A/B operand buses, which feed the bitwise units (and, or, xor, nor) and the adder. The write port takes the writeback result (ALU output or memory load data, selected outside this block).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width (2**ADDR_W = 32 registers)
- SP_RESET, 32'h0000_3FFC, reset value of register 29 ($sp)

- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high
- read_reg1  input  ADDR_W  index for read port 1 (rs)
- read_reg2  input  ADDR_W  index for read port 2 (rt)
- write_reg  input  ADDR_W  index for write port (rd/rt, muxed upstream)
- write_data  input  DATA_W  value to write
- reg_write  input  1  write enable from control unit
- read_data1  output  DATA_W  contents of read_reg1, drives ALU operand A
- read_data2  output  DATA_W  contents of read_reg2, drives ALU operand B

## Operation
- Storage: 32 x DATA_W flip-flop array, regs[0..31].
- Reset (rst=1, any time, independent of clk): regs[29] <= SP_RESET; every other register <= 0. Resulting outputs:
  - read_data1 / read_data2 = 0 for any index except 29;
  - SP_RESET for index 29.
- Reset asserted mid-cycle: the array clears immediately and any pending write is lost.
- Write: on a rising clk edge with rst=0 and reg_write=1, regs[write_reg] <= write_data.
- Register 0 ($zero):
  - a write to index 0 is ignored;
  - regs[0] stays 0 permanently;
  - reads of index 0 return 0 regardless of storage. Enforce this on the read path as well as on the write path.
- reg_write=0: no register changes. write_reg and write_data are don't-care.
- Read: read_data1 = (read_reg1==0) ? 0 : regs[read_reg1]; read_data2 is defined the same way from read_reg2. Both are purely combinational from the address inputs and the array.
- No write-to-read bypass:
  - when write_reg equals a read index in the same cycle, the read returns the pre-edge (old) value until the edge;
  - after the edge, it returns the new value;
  - this matches single-cycle semantics, where an instruction reads its sources before its own writeback.
- Both read ports may address the same register simultaneously; both return the identical value.
- Index width is exactly ADDR_W. No out-of-range index exists, so no wrap or saturation logic is needed.

## Timing
- Read latency: 0 cycles (combinational). Outputs settle within the same cycle after an address or array change.
- Write latency: 1 edge. The value is visible on the read ports immediately after the rising edge on which reg_write=1.
- rst deassertion:
  - the first edge with rst=0 may perform a write;
  - rst deassertion must be synchronous to clk (it is synchronized externally);
  - rst assertion takes effect asynchronously.
- Simultaneous rst=1 and a write edge: reset wins and the register holds its reset value.
- No handshake, no stall input. One write per cycle maximum.
- Critical path: read mux (32:1 x 32 bits) into the ALU. Keep the read mux a flat 32:1 per bit, with no extra logic beyond the index-0 force.

## Test plan
- Reset values:
  - assert rst, then read every index through both ports;
  - expect 0 on all ports, except 32'h0000_3FFC on index 29.
- Basic write/read:
  - write 32'hDEAD_BEEF to r8 with reg_write=1, then read_reg1=8 and read_reg2=8;
  - expect both outputs = 32'hDEAD_BEEF after the edge, and the old value (0) before the edge in the same cycle.
- $zero protection:
  - write 32'hFFFF_FFFF to r0;
  - expect read_data1 = read_data2 = 0 on the following cycle.
- Write-enable gating:
  - with reg_write=0, present write_reg=5, write_data=32'h1234_5678 for 3 edges;
  - expect r5 to read 0.
- Async reset mid-operation:
  - fill r1..r31 with the value (index*32'h0101_0101);
  - pulse rst between clock edges for 2 ns;
  - expect all registers back to reset values before the next edge, with r29 = SP_RESET.
- Dual-port independence:
  - write r3=32'hAAAA_5555 and r4=32'h5555_AAAA, then set read_reg1=3, read_reg2=4;
  - expect read_data1 XOR read_data2 = 32'hFFFF_FFFF;
  - swap the indices and expect the outputs to swap within the same cycle.
